// File: rtl/key_event_queue.sv
// key_event_queue: debounced key levels -> queued single-key press events.
// Hold-to-repeat is built only when KEY_EVENT_AUTO_REPEAT_EN is defined.
module key_event_queue #(
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_W        = 25,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000
) (
   input  logic       sysclk,
   input  logic       rst,
   input  logic [4:0] keys_deb,
   output logic [2:0] ev_code,
   output logic       ev_repeat,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic       ev_drop
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
`ifdef KEY_EVENT_AUTO_REPEAT_EN
   localparam int DW = 4;
`else
   localparam int DW = 3;
`endif

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
       REPEAT_RATE > REPEAT_DELAY || CNT_W < 1) begin : g_bad_cfg
      $error("key_event_queue: illegal parameter set");
   end

   logic [4:0]    r_prev_keys;
   logic [4:0]    r_pend;
   logic          r_drop;
   logic [DW-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic [4:0]    w_rise;
   logic [4:0]    w_clr;
   logic [4:0]    w_keep;
   logic [4:0]    w_rise_new;
   logic [4:0]    w_rep_new;
   logic [2:0]    w_idx;
   logic          w_pop;
   logic          w_push;
   logic          w_lost;
   logic [DW-1:0] w_push_data;
   logic [DW-1:0] w_head;

   assign w_rise     = keys_deb & ~r_prev_keys;
   assign w_pop      = ev_valid & ev_ready;
   // a full queue still takes a push when the head leaves this cycle
   assign w_push     = (|r_pend) &
                       ((r_count < CW'(FIFO_DEPTH)) | w_pop);
   assign w_clr      = w_push ? (5'b00001 << w_idx) : 5'b00000;
   assign w_keep     = r_pend & ~w_clr;
   assign w_rise_new = w_rise & ~w_keep;
   assign w_lost     = |(w_rise & w_keep);

   assign w_head   = r_mem[r_rd_ptr];
   assign ev_code  = w_head[2:0];
   assign ev_valid = (r_count != '0);
   assign ev_drop  = r_drop;

   // lowest-index pending key wins the single push slot
   always_comb begin
      w_idx = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (r_pend[i]) w_idx = 3'(i);
      end
   end

`ifdef KEY_EVENT_AUTO_REPEAT_EN
   logic [CNT_W-1:0] r_cnt;
   logic [4:0]       r_tag;
   logic             w_stable;
   logic             w_hit;
   logic [4:0]       w_rep;

   // only a steady, single direction key is eligible for repeat
   assign w_stable = (keys_deb[3:0] == r_prev_keys[3:0]) &&
                     $onehot(keys_deb[3:0]);
   assign w_hit    = w_stable &&
                     (r_cnt == CNT_W'(REPEAT_DELAY - 1));
   assign w_rep    = w_hit ? {1'b0, keys_deb[3:0]} : 5'b00000;
   // a repeat landing on a still-pending key is simply skipped
   assign w_rep_new   = w_rep & ~w_keep;
   assign w_push_data = {r_tag[w_idx], w_idx};
   assign ev_repeat   = w_head[3];

   // hold counter: first repeat after DELAY, then every RATE
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (!w_stable) begin
         r_cnt <= '0;
      end else if (w_hit) begin
         r_cnt <= CNT_W'(REPEAT_DELAY - REPEAT_RATE);
      end else if (r_cnt != '1) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // repeat tag follows whichever source last armed the pending bit
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         r_tag <= '0;
      end else begin
         r_tag <= (r_tag & ~w_rise_new) | w_rep_new;
      end
   end
`else
   assign w_rep_new   = 5'b00000;
   assign w_push_data = w_idx;
   assign ev_repeat   = 1'b0;
`endif

   // edge history, pending mask and sticky overflow flag
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         r_prev_keys <= '0;
         r_pend      <= '0;
         r_drop      <= 1'b0;
      end else begin
         r_prev_keys <= keys_deb;
         r_pend      <= w_keep | w_rise | w_rep_new;
         if (w_lost) r_drop <= 1'b1;
      end
   end

   // event FIFO storage, pointers and occupancy
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue: directed bench for key_event_queue.
// Repeat expectations follow KEY_EVENT_AUTO_REPEAT_EN.
module tb_key_event_queue;

`ifdef KEY_EVENT_AUTO_REPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       sysclk;
   logic       rst;
   logic [4:0] keys_deb;
   logic [2:0] ev_code;
   logic       ev_repeat;
   logic       ev_valid;
   logic       ev_ready;
   logic       ev_drop;

   int n_chk;
   int n_fail;

   key_event_queue #(
      .FIFO_DEPTH   (4),
      .CNT_W        (8),
      .REPEAT_DELAY (8),
      .REPEAT_RATE  (4)
   ) dut (
      .sysclk    (sysclk),
      .rst       (rst),
      .keys_deb  (keys_deb),
      .ev_code   (ev_code),
      .ev_repeat (ev_repeat),
      .ev_valid  (ev_valid),
      .ev_ready  (ev_ready),
      .ev_drop   (ev_drop)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge sysclk);
         #1;
      end
   endtask

   // key level high for exactly one sampling edge
   task automatic press(input logic [4:0] m);
      keys_deb = m;
      step(1);
      keys_deb = 5'b00000;
   endtask

   task automatic chk_ev(input string tag, input int code);
      chk({tag, "_v"}, ev_valid, 1);
      chk({tag, "_c"}, ev_code, code);
      chk({tag, "_r"}, ev_repeat, 0);
   endtask

   initial begin
      bit ev;
      n_chk    = 0;
      n_fail   = 0;
      rst      = 1'b1;
      keys_deb = 5'b00000;
      ev_ready = 1'b0;
      #1;
      chk("rst_valid", ev_valid, 0);
      chk("rst_code", ev_code, 0);
      chk("rst_rep", ev_repeat, 0);
      chk("rst_drop", ev_drop, 0);
      step(2);
      rst = 1'b0;
      step(1);

      // single press of North
      ev_ready = 1'b1;
      press(5'b00100);
      chk("t2_k", ev_valid, 0);
      step(1);
      chk_ev("t2_k1", 2);
      step(1);
      chk("t2_k2", ev_valid, 0);

      // simultaneous rises drain in ascending order
      press(5'b11011);
      step(1);
      chk_ev("t3_e0", 0);
      step(1);
      chk_ev("t3_e1", 1);
      step(1);
      chk_ev("t3_e3", 3);
      step(1);
      chk_ev("t3_e4", 4);
      step(1);
      chk("t3_end", ev_valid, 0);
      chk("t3_drop", ev_drop, 0);

      // hold East: repeats only with the macro
      keys_deb = 5'b00001;
      for (int j = 0; j <= 22; j++) begin
         step(1);
         if (j == 19) keys_deb = 5'b00000;
         ev = (j == 1) ||
              (AR && (j == 9 || j == 13 || j == 17));
         chk($sformatf("east_v%0d", j), ev_valid, ev);
         if (ev) begin
            chk($sformatf("east_c%0d", j), ev_code, 0);
            chk($sformatf("east_r%0d", j), ev_repeat,
                (j == 1) ? 0 : 1);
         end
      end

      // hold func_switch: never repeats
      keys_deb = 5'b10000;
      for (int j = 0; j <= 22; j++) begin
         step(1);
         if (j == 19) keys_deb = 5'b00000;
         ev = (j == 1);
         chk($sformatf("fsw_v%0d", j), ev_valid, ev);
         if (ev) chk_ev("fsw_ev", 4);
      end

      // backpressure: fill, key 4 pending, second press of 4 drops
      ev_ready = 1'b0;
      press(5'b00001);
      press(5'b00010);
      press(5'b00100);
      press(5'b01000);
      press(5'b10000);
      step(1);
      chk("t4_nodrop", ev_drop, 0);
      chk("t4_hold_c", ev_code, 0);
      press(5'b10000);
      chk("t4_drop", ev_drop, 1);
      chk_ev("t4_stable", 0);
      ev_ready = 1'b1;
      step(1);
      chk_ev("t4_e1", 1);
      step(1);
      chk_ev("t4_e2", 2);
      step(1);
      chk_ev("t4_e3", 3);
      step(1);
      chk_ev("t4_e4", 4);
      step(1);
      chk("t4_end", ev_valid, 0);
      chk("t4_sticky", ev_drop, 1);

      // async reset with three events queued
      ev_ready = 1'b0;
      press(5'b00001);
      press(5'b00010);
      press(5'b00100);
      step(1);
      chk_ev("t1_pre", 0);
      #2 rst = 1'b1;
      #1;
      chk("t1_valid", ev_valid, 0);
      chk("t1_drop", ev_drop, 0);
      chk("t1_code", ev_code, 0);
      #2 rst = 1'b0;
      ev_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         step(1);
         chk($sformatf("t1_stale%0d", j), ev_valid, 0);
      end

      // full queue: push and pop on one edge, plus a new rise
      ev_ready = 1'b0;
      press(5'b00001);
      press(5'b00010);
      press(5'b00100);
      press(5'b01000);
      press(5'b10000);
      ev_ready = 1'b1;
      press(5'b00001);
      ev_ready = 1'b0;
      step(2);
      chk_ev("t7_hold", 1);
      chk("t7_drop", ev_drop, 0);
      ev_ready = 1'b1;
      step(1);
      chk_ev("t7_e2", 2);
      step(1);
      chk_ev("t7_e3", 3);
      step(1);
      chk_ev("t7_e4", 4);
      step(1);
      chk_ev("t7_e0", 0);
      step(1);
      chk("t7_end", ev_valid, 0);
      chk("t7_drop2", ev_drop, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
